// File: rtl/phase_seq_pkg.sv
// -----------------------------------------------------------------------------
// phase_seq_pkg
//   Shared types and constants for the phase-driven ALU sequencer.
//   - state_e    : sequencer FSM states
//   - op_e       : ALU operation codes
//   - PHASE_W    : number of phase lines from the 4-phase generator
//   - stray_rise : true when any phase rises other than the expected one
// -----------------------------------------------------------------------------
package phase_seq_pkg;

  localparam int PHASE_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    P0    = 3'd2,
    P1    = 3'd3,
    P2    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  // Any rise outside the expected one-hot position, including the expected bit
  // rising together with another one, counts as out of order.
  function automatic logic stray_rise(input logic [PHASE_W-1:0] rise,
                                      input logic [PHASE_W-1:0] expected);
    return |(rise & ~expected);
  endfunction

endpackage

// File: rtl/phase_sync_edge.sv
// -----------------------------------------------------------------------------
// phase_sync_edge
//   Resynchronises the phase bits into the Clock domain and produces a
//   one-cycle rise strobe per bit (rise = synced & ~previous).
//   A rise is presented SYNC_STAGES+1 Clocks after the input edge, counting the
//   edge at which the consumer acts on it. SYNC_STAGES=0 bypasses the
//   synchroniser for phases that are already on Clock.
// Ports
//   Clock    in  system clock, rising edge
//   Clear    in  asynchronous active-low reset
//   phase_in in  raw phase bits [3:0]
//   rise     out rising-edge strobes [3:0]
// -----------------------------------------------------------------------------
module phase_sync_edge
  import phase_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic [PHASE_W-1:0] phase_in,
  output logic [PHASE_W-1:0] rise
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] prev_q;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign phase_q = phase_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][PHASE_W-1:0] sync_q;

    always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= phase_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign phase_q = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      prev_q <= '0;
    end else begin
      prev_q <= phase_q;
    end
  end

  // Only edges matter, so glitchy 0000 or two-hot levels between phases are
  // harmless as long as each bit rises once per cycle.
  assign rise = phase_q & ~prev_q;

endmodule

// File: rtl/phase_alu_sequencer.sv
// -----------------------------------------------------------------------------
// phase_alu_sequencer
//   Sequences one ALU operation across a full cycle of the 4-phase generator:
//   Phase0 loads the working operands, Phase1 computes, Phase2 writes Result,
//   Phase3 pulses Done.
// Parameters
//   WIDTH        operand/result width
//   SYNC_STAGES  synchroniser flops per phase bit (0 = phases already on Clock)
// Ports
//   Clock, Clear            clock, async active-low reset
//   Phase0..Phase3          one-hot phase inputs
//   Start, Op, A, B         request and operands (captured when Busy=0)
//   Result, Carry           registered result, carry/no-borrow
//   Busy, Done              operation in progress, one-cycle completion pulse
//   Phase_Err               sticky out-of-order phase flag
// Configuration
//   PHASE_SEQ_CHECK_EN      when defined, an unexpected phase rise in P0/P1/P2
//                           aborts the operation and sets Phase_Err; otherwise
//                           such rises are ignored and Phase_Err is tied 0.
// -----------------------------------------------------------------------------
module phase_alu_sequencer
  import phase_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Phase0,
  input  logic             Phase1,
  input  logic             Phase2,
  input  logic             Phase3,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Busy,
  output logic             Done,
  output logic             Phase_Err
);

  logic [PHASE_W-1:0] rise;

  phase_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .Clock    (Clock),
    .Clear    (Clear),
    .phase_in ({Phase3, Phase2, Phase1, Phase0}),
    .rise     (rise)
  );

  state_e           state_q, state_d;
  op_e              op_cap_q, op_wrk_q;
  logic [WIDTH-1:0] a_cap_q, b_cap_q, a_wrk_q, b_wrk_q;
  logic [WIDTH-1:0] tmp_q, result_q;
  logic             tmp_c_q, carry_q, done_q;

  logic             capture, load_wrk, compute, write_res, done_d;
  logic [WIDTH:0]   alu_sum;
`ifdef PHASE_SEQ_CHECK_EN
  logic             err_set;
  logic             err_q;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    load_wrk  = 1'b0;
    compute   = 1'b0;
    write_res = 1'b0;
    done_d    = 1'b0;
`ifdef PHASE_SEQ_CHECK_EN
    err_set   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          capture = 1'b1;
          state_d = ARMED;
        end
      end
      // Sync-up point: only a Phase0 rise starts the sequence.
      ARMED: begin
        if (rise[0]) begin
          load_wrk = 1'b1;
          state_d  = P0;
        end
      end
      P0: begin
`ifdef PHASE_SEQ_CHECK_EN
        if (stray_rise(rise, 4'b0010)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else
`endif
        if (rise[1]) begin
          compute = 1'b1;
          state_d = P1;
        end
      end
      P1: begin
`ifdef PHASE_SEQ_CHECK_EN
        if (stray_rise(rise, 4'b0100)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else
`endif
        if (rise[2]) begin
          write_res = 1'b1;
          state_d   = P2;
        end
      end
      P2: begin
`ifdef PHASE_SEQ_CHECK_EN
        if (stray_rise(rise, 4'b1000)) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else
`endif
        if (rise[3]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU: WIDTH+1-bit result; SUB is A + ~B + 1 so the top bit is no-borrow.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_sum = '0;
    unique case (op_wrk_q)
      OP_ADD:  alu_sum = {1'b0, a_wrk_q} + {1'b0, b_wrk_q};
      OP_SUB:  alu_sum = {1'b0, a_wrk_q} + {1'b0, ~b_wrk_q} + {{WIDTH{1'b0}}, 1'b1};
      OP_AND:  alu_sum = {1'b0, a_wrk_q & b_wrk_q};
      OP_XOR:  alu_sum = {1'b0, a_wrk_q ^ b_wrk_q};
      default: alu_sum = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= IDLE;
      op_cap_q <= OP_ADD;
      a_cap_q  <= '0;
      b_cap_q  <= '0;
      op_wrk_q <= OP_ADD;
      a_wrk_q  <= '0;
      b_wrk_q  <= '0;
      tmp_q    <= '0;
      tmp_c_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (capture) begin
        op_cap_q <= op_e'(Op);
        a_cap_q  <= A;
        b_cap_q  <= B;
      end
      if (load_wrk) begin
        op_wrk_q <= op_cap_q;
        a_wrk_q  <= a_cap_q;
        b_wrk_q  <= b_cap_q;
      end
      if (compute) begin
        {tmp_c_q, tmp_q} <= alu_sum;
      end
      if (write_res) begin
        result_q <= tmp_q;
        carry_q  <= tmp_c_q;
      end
    end
  end

`ifdef PHASE_SEQ_CHECK_EN
  // Sticky until the next accepted Start.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (capture) begin
      err_q <= 1'b0;
    end
  end
  assign Phase_Err = err_q;
`else
  assign Phase_Err = 1'b0;
`endif

  assign Result = result_q;
  assign Carry  = carry_q;
  assign Busy   = (state_q != IDLE);
  assign Done   = done_q;

endmodule

// File: tb/tb_phase_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_alu_sequencer
//   Table-driven check of the phase ALU sequencer (WIDTH=8, SYNC_STAGES=2),
//   plus hand-written sequences for reset abort, ignored rises while ARMED,
//   Start held through Busy, Done latency and the phase-order checker
//   (PHASE_SEQ_CHECK_EN selects which checker behaviour is expected).
// -----------------------------------------------------------------------------
module tb_phase_alu_sequencer;
  import phase_seq_pkg::*;

  localparam int WIDTH = 8;

  logic             Clock = 1'b0;
  logic             Clear;
  logic             Phase0, Phase1, Phase2, Phase3;
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A, B;
  logic [WIDTH-1:0] Result;
  logic             Carry, Busy, Done, Phase_Err;

  phase_alu_sequencer #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .Phase0    (Phase0),
    .Phase1    (Phase1),
    .Phase2    (Phase2),
    .Phase3    (Phase3),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .Result    (Result),
    .Carry     (Carry),
    .Busy      (Busy),
    .Done      (Done),
    .Phase_Err (Phase_Err)
  );

  always #5 Clock = ~Clock;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt;
  logic prev_busy, busy_before_done, busy_at_done;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             c;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One Clock, sampled at the falling edge; tracks Done pulses and the Busy
  // level around them.
  task automatic step();
    @(negedge Clock);
    if (Done === 1'b1) begin
      done_cnt++;
      busy_before_done = prev_busy;
      busy_at_done     = Busy;
    end
    prev_busy = Busy;
  endtask

  task automatic set_phase(input int k);
    logic [3:0] one;
    one = 4'b0001;
    if (k < 0) {Phase3, Phase2, Phase1, Phase0} = 4'b0000;
    else       {Phase3, Phase2, Phase1, Phase0} = one << k;
  endtask

  task automatic hold_phase(input int k, input int n);
    set_phase(k);
    repeat (n) step();
  endtask

  task automatic start_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    step();
    Start = 1'b0;
  endtask

  task automatic run_seq();
    hold_phase(0, 4);
    hold_phase(1, 4);
    hold_phase(2, 4);
    hold_phase(3, 4);
  endtask

  initial begin
    vecs[0] = '{OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1};
    vecs[1] = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b0};
    vecs[2] = '{OP_XOR, 8'hAA, 8'hFF, 8'h55, 1'b0};
    vecs[3] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[4] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[5] = '{OP_SUB, 8'h07, 8'h05, 8'h02, 1'b1};
    vecs[6] = '{OP_SUB, 8'h33, 8'h33, 8'h00, 1'b1};
    vecs[7] = '{OP_ADD, 8'hFF, 8'hFF, 8'hFE, 1'b1};

    Clear = 1'b0;
    Start = 1'b0;
    Op    = 2'b00;
    A     = '0;
    B     = '0;
    set_phase(-1);
    done_cnt  = 0;
    prev_busy = 1'b0;
    busy_before_done = 1'b0;
    busy_at_done     = 1'b0;

    // Reset state
    repeat (2) @(negedge Clock);
    check("rst_result", Result, 8'h00);
    check("rst_carry", Carry, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_err", Phase_Err, 1'b0);
    Clear = 1'b1;
    step();

    // Table of operations, each over a clean 0,1,2,3 phase cycle
    for (int i = 0; i < 8; i++) begin
      done_cnt = 0;
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_after_start", i), Busy, 1'b1);
      run_seq();
      check($sformatf("v%0d_result", i), Result, vecs[i].res);
      check($sformatf("v%0d_carry", i), Carry, vecs[i].c);
      check($sformatf("v%0d_done_count", i), done_cnt, 1);
      check($sformatf("v%0d_busy_frame", i), {busy_before_done, busy_at_done}, 2'b10);
      check($sformatf("v%0d_err", i), Phase_Err, 1'b0);
    end

    // Clear mid-P1 aborts without Done; a fresh Start then works
    done_cnt = 0;
    start_op(OP_ADD, 8'h01, 8'h02);
    hold_phase(0, 4);
    hold_phase(1, 4);
    check("abort_busy_pre", Busy, 1'b1);
    Clear = 1'b0;
    #1;
    check("abort_result", Result, 8'h00);
    check("abort_carry", Carry, 1'b0);
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    check("abort_err", Phase_Err, 1'b0);
    step();
    Clear = 1'b1;
    step();
    start_op(OP_ADD, 8'h01, 8'h02);
    run_seq();
    check("restart_result", Result, 8'h03);
    check("restart_done_count", done_cnt, 1);

    // Phase3 rise while ARMED is ignored
    hold_phase(-1, 4);
    done_cnt = 0;
    start_op(OP_XOR, 8'h0F, 8'h3C);
    hold_phase(3, 5);
    check("armed_p3_busy", Busy, 1'b1);
    check("armed_p3_no_done", done_cnt, 0);
    run_seq();
    check("armed_p3_result", Result, 8'h33);
    check("armed_p3_done_count", done_cnt, 1);
    check("armed_p3_err", Phase_Err, 1'b0);

    // Start held through Busy: no second capture until the Done cycle
    done_cnt = 0;
    Start = 1'b1;
    Op    = OP_ADD;
    A     = 8'h10;
    B     = 8'h20;
    step();
    A = 8'h77;
    B = 8'h11;
    run_seq();
    check("held_result", Result, 8'h30);
    check("held_done_count", done_cnt, 1);
    check("held_busy_at_done", busy_at_done, 1'b0);
    check("held_reaccept_busy", Busy, 1'b1);
    Start = 1'b0;
    done_cnt = 0;
    run_seq();
    check("held_second_result", Result, 8'h88);
    check("held_second_carry", Carry, 1'b0);
    check("held_second_done", done_cnt, 1);

    // Done exactly 3 Clocks after Phase3 rises at the input
    done_cnt = 0;
    start_op(OP_AND, 8'hFF, 8'h0F);
    hold_phase(0, 4);
    hold_phase(1, 4);
    hold_phase(2, 4);
    set_phase(3);
    step();
    check("lat_c1", Done, 1'b0);
    step();
    check("lat_c2", Done, 1'b0);
    step();
    check("lat_c3", Done, 1'b1);
    step();
    check("lat_c4", Done, 1'b0);
    check("lat_result", Result, 8'h0F);

    // Out-of-order sequence 0,2
    done_cnt = 0;
    start_op(OP_ADD, 8'h01, 8'h01);
    hold_phase(0, 4);
    hold_phase(2, 5);
`ifdef PHASE_SEQ_CHECK_EN
    check("order_err", Phase_Err, 1'b1);
    check("order_busy", Busy, 1'b0);
    check("order_no_done", done_cnt, 0);
    check("order_result_kept", Result, 8'h0F);
    start_op(OP_SUB, 8'h09, 8'h03);
    check("order_err_cleared", Phase_Err, 1'b0);
    run_seq();
    check("order_next_result", Result, 8'h06);
    check("order_next_carry", Carry, 1'b1);
    check("order_next_done", done_cnt, 1);
`else
    check("order_err_tied", Phase_Err, 1'b0);
    check("order_busy_waits", Busy, 1'b1);
    check("order_no_done", done_cnt, 0);
    hold_phase(1, 4);
    hold_phase(2, 4);
    hold_phase(3, 4);
    check("order_result", Result, 8'h02);
    check("order_carry", Carry, 1'b0);
    check("order_done", done_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
